// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
//  Module   : alu_ctrl_pkg
//  Purpose  : Shared ALU_Op, operation-code, funct7 and FSM-state constants
//             for the multi-cycle ALU control decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam logic [2:0] C_ALUOP_R = 3'b000;
    localparam logic [2:0] C_ALUOP_I = 3'b001;
    localparam logic [2:0] C_ALUOP_U = 3'b010;

    localparam logic [3:0] C_OP_ADD     = 4'b0000;
    localparam logic [3:0] C_OP_SUB     = 4'b0001;
    localparam logic [3:0] C_OP_OR      = 4'b0010;
    localparam logic [3:0] C_OP_AND     = 4'b0011;
    localparam logic [3:0] C_OP_LUI     = 4'b0100;
    localparam logic [3:0] C_OP_SLL     = 4'b0101;
    localparam logic [3:0] C_OP_SRL     = 4'b0110;
    localparam logic [3:0] C_OP_XOR     = 4'b0111;
    localparam logic [3:0] C_OP_SRA     = 4'b1000;
    localparam logic [3:0] C_OP_SLT     = 4'b1001;
    localparam logic [3:0] C_OP_SLTU    = 4'b1010;
    localparam logic [3:0] C_OP_MUL     = 4'b1011;
    localparam logic [3:0] C_OP_MULH    = 4'b1100;
    localparam logic [3:0] C_OP_DIV     = 4'b1101;
    localparam logic [3:0] C_OP_REM     = 4'b1110;
    localparam logic [3:0] C_OP_ILLEGAL = 4'b1111;

    localparam logic [6:0] C_F7_BASE   = 7'b0000000;
    localparam logic [6:0] C_F7_ALT    = 7'b0100000;
    localparam logic [6:0] C_F7_MULDIV = 7'b0000001;

    localparam int         C_ST_W    = 2;
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_BUSY = 2'd1;
    localparam logic [1:0] C_ST_OUT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
//  Module   : alu_op_decode
//  Purpose  : Combinational decode of {funct7, ALU_Op, funct3} to an ALU
//             operation code plus illegal / multiply / divide flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int M_EXT_EN = 1
) (
    input  logic [6:0] i_funct7,
    input  logic [2:0] i_alu_op,
    input  logic [2:0] i_funct3,
    output logic [3:0] o_code,
    output logic       o_illegal,
    output logic       o_is_mul,
    output logic       o_is_div
);

    always_comb begin
        o_code   = C_OP_ILLEGAL;
        o_is_mul = 1'b0;
        o_is_div = 1'b0;
        case (i_alu_op)
            C_ALUOP_R: begin
                case (i_funct7)
                    C_F7_BASE: begin
                        case (i_funct3)
                            3'b000:  o_code = C_OP_ADD;
                            3'b001:  o_code = C_OP_SLL;
                            3'b010:  o_code = C_OP_SLT;
                            3'b011:  o_code = C_OP_SLTU;
                            3'b100:  o_code = C_OP_XOR;
                            3'b101:  o_code = C_OP_SRL;
                            3'b110:  o_code = C_OP_OR;
                            default: o_code = C_OP_AND;
                        endcase
                    end
                    C_F7_ALT: begin
                        if (i_funct3 == 3'b000) o_code = C_OP_SUB;
                        else if (i_funct3 == 3'b101) o_code = C_OP_SRA;
                    end
                    C_F7_MULDIV: begin
                        if (M_EXT_EN != 0) begin
                            case (i_funct3)
                                3'b000: begin o_code = C_OP_MUL;  o_is_mul = 1'b1; end
                                3'b001: begin o_code = C_OP_MULH; o_is_mul = 1'b1; end
                                3'b100: begin o_code = C_OP_DIV;  o_is_div = 1'b1; end
                                3'b110: begin o_code = C_OP_REM;  o_is_div = 1'b1; end
                                default: o_code = C_OP_ILLEGAL;
                            endcase
                        end
                    end
                    default: o_code = C_OP_ILLEGAL;
                endcase
            end
            C_ALUOP_I: begin
                // Immediate shifts are the only I-type forms that constrain funct7
                case (i_funct3)
                    3'b000:  o_code = C_OP_ADD;
                    3'b010:  o_code = C_OP_SLT;
                    3'b011:  o_code = C_OP_SLTU;
                    3'b100:  o_code = C_OP_XOR;
                    3'b110:  o_code = C_OP_OR;
                    3'b111:  o_code = C_OP_AND;
                    3'b001: begin
                        if (i_funct7 == C_F7_BASE) o_code = C_OP_SLL;
                    end
                    default: begin
                        if (i_funct7 == C_F7_BASE) o_code = C_OP_SRL;
                        else if (i_funct7 == C_F7_ALT) o_code = C_OP_SRA;
                    end
                endcase
            end
            C_ALUOP_U: o_code = C_OP_LUI;
            default:   o_code = C_OP_ILLEGAL;
        endcase
    end

    assign o_illegal = (o_code == C_OP_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/alu_control_mc.sv
// ============================================================================
//  Module   : alu_control_mc
//  Purpose  : Registered ALU control decoder with valid/ready handshake and
//             latency sequencing for multi-cycle MUL/DIV operations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int M_EXT_EN   = 1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [OP_W-1:0] alu_operation_o,
    output logic            illegal_o,
    output logic            busy_o
);

    localparam int C_MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W   = $clog2(C_MAX_CYC);
    localparam logic [C_CNT_W-1:0] C_MUL_LOAD = C_CNT_W'(MUL_CYCLES - 2);
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD = C_CNT_W'(DIV_CYCLES - 2);

    logic [C_ST_W-1:0]  r_state;
    logic [C_ST_W-1:0]  w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [OP_W-1:0]    r_op;
    logic               r_illegal;

    logic [3:0] w_code;
    logic       w_illegal;
    logic       w_is_mul;
    logic       w_is_div;
    logic       w_ready;
    logic       w_accept;

    alu_op_decode #(
        .M_EXT_EN (M_EXT_EN)
    ) u_decode (
        .i_funct7  (funct7_i),
        .i_alu_op  (alu_op_i),
        .i_funct3  (funct3_i),
        .o_code    (w_code),
        .o_illegal (w_illegal),
        .o_is_mul  (w_is_mul),
        .o_is_div  (w_is_div)
    );

    // ready_o depends combinationally on ready_i so OUT can hand over back-to-back
    assign w_ready  = (r_state == C_ST_IDLE) || ((r_state == C_ST_OUT) && ready_i);
    assign w_accept = valid_i && w_ready && !flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush_i) begin
            w_state_nxt = C_ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                C_ST_IDLE, C_ST_OUT: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            w_state_nxt = C_ST_BUSY;
                            w_cnt_nxt   = C_MUL_LOAD;
                        end else if (w_is_div) begin
                            w_state_nxt = C_ST_BUSY;
                            w_cnt_nxt   = C_DIV_LOAD;
                        end else begin
                            w_state_nxt = C_ST_OUT;
                        end
                    end else if ((r_state == C_ST_OUT) && ready_i) begin
                        w_state_nxt = C_ST_IDLE;
                    end
                end
                C_ST_BUSY: begin
                    if (r_cnt == '0) w_state_nxt = C_ST_OUT;
                    else             w_cnt_nxt   = r_cnt - C_CNT_W'(1);
                end
                default: begin
                    w_state_nxt = C_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= C_ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op      <= OP_W'(w_code);
                r_illegal <= w_illegal;
            end
        end
    end

    assign ready_o         = w_ready;
    assign valid_o         = (r_state == C_ST_OUT);
    assign busy_o          = (r_state == C_ST_BUSY);
    assign alu_operation_o = r_op;
    assign illegal_o       = r_illegal;

endmodule

`default_nettype wire
